sram_controller: RTL
====================

# sram_controller

Bus-side responder that turns single-word Wishbone classic requests from the CPU's memory stage into asynchronous SRAM cycles on one 1M×32 bank (BaseRAM or ExtRAM). It is the initiator toward the board's two 16-bit SRAM chips; the top level instantiates one copy per bank. It owns the shared data bus tri-state and guarantees the write-enable pulse is bracketed by stable address, data and byte enables.

## Interface
Parameters:
- DATA_WIDTH, 32, bus and SRAM data width
- ADDR_WIDTH, 20, SRAM word-address width
Ports:
- clk_50M  in  1  system clock; single clock domain
- reset_btn  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle active
- wb_stb_i  in  1  request strobe; held by master until ack
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  32  byte address; bits [21:2] select the word
- wb_sel_i  in  4  byte lane enables, bit0 = [7:0]
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid with ack
- wb_ack_o  out  1  one-cycle completion pulse
- sram_addr  out  20  SRAM word address
- sram_data  inout  32  SRAM data bus
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  4  byte enables, active low

## Operation
- FSM states: IDLE, READ, READ_2, WRITE, WRITE_2, WRITE_3, DONE.
- IDLE: when wb_cyc_i & wb_stb_i are both high, latch wb_adr_i[21:2], ~wb_sel_i, wb_dat_i, wb_we_i into registers. Go to READ if wb_we_i = 0, else WRITE. Requests are accepted only in IDLE.
- READ: ce_n=0, oe_n=0, be_n=latched. Next state READ_2.
- READ_2: same controls; sample sram_data into wb_dat_o at the end of the cycle. Next state DONE.
- WRITE: ce_n=0, oe_n=1, we_n=1; drive latched data. Next state WRITE_2.
- WRITE_2: we_n=0. Next state WRITE_3.
- WRITE_3: we_n=1; data and address remain driven (hold time). Next state DONE.
- DONE: ce_n=oe_n=we_n=1, be_n=4'b1111; wb_ack_o=1 for exactly this cycle. Next state IDLE.
- sram_data is driven only in WRITE, WRITE_2 and WRITE_3. In every other state it is high-Z.
- A write with wb_sel_i=0 still runs the full cycle with be_n=4'b1111; no bytes change.
- Abort: if wb_cyc_i falls after acceptance, the SRAM cycle completes unchanged (the we_n pulse is never truncated). DONE is still visited, but wb_ack_o stays 0.
- Reset (any state, including mid-write): next edge goes to IDLE. All outputs return to their reset values.
- Reset values: wb_ack_o=0, wb_dat_o=0, sram_addr=0, ce_n=oe_n=we_n=1, be_n=4'b1111, sram_data high-Z.

## Timing
- All outputs are registered; none depends combinationally on wb_* inputs.
- Read: request seen in IDLE at edge 0; ack high in cycle 3; wb_dat_o valid in that same cycle and held until the next read completes.
- Write: ack in cycle 4; we_n low for exactly 1 cycle (20 ns), with ≥1 cycle of setup and hold on address, data and be_n.
- Back-to-back: a request held high in the ack cycle is not taken. It is accepted in the IDLE cycle that follows, so there is a minimum of 1 idle cycle between SRAM cycles.

## Configuration
- SRAM_CTRL_EXTRA_WAIT_EN defined: adds state READ_3 after READ_2 (sampling moves to READ_3) and lengthens WRITE_2 to 2 cycles of we_n=0. Read ack moves to cycle 4, write ack to cycle 5.
- Undefined: timing exactly as above.

## Structure
- Package sram_ctrl_pkg contains the state enum sram_state_t (including READ_3, which is used only under the macro) and the localparams SRAM_WORD_LSB=2 and SRAM_WORD_MSB=21.
- Single module, no sub-module. The tri-state is one continuous assign gated by a registered drive-enable flop.

## Test plan
- Write 0xDEADBEEF to 0x80000010, sel=4'hF. Required: sram_addr=20'h00004, be_n=0000, we_n low for exactly one cycle, ack in cycle 4. A read-back of the same address acks in cycle 3 with 0xDEADBEEF.
- Byte write of 0x0000AB00 to 0x80000010 with sel=4'b0010. Required: be_n=4'b1101. A read-back returns 0xDEADABEF.
- Two reads held back-to-back at 0x0 and 0x4, preloaded with 0x11111111 and 0x22222222. Required: acks 4 cycles apart and correct data on each ack; sram_data is never driven by the DUT.
- Assert reset_btn during WRITE_2. Required: the next cycle shows we_n=1, ce_n=1, data high-Z, no ack. The following write to a different address completes normally.
- Drop wb_cyc_i in READ. Required: no ack pulse, return to IDLE after DONE, and a new request is accepted on the next IDLE.
- With SRAM_CTRL_EXTRA_WAIT_EN defined, repeat the first scenario. Required: we_n low for 2 cycles, write ack in cycle 5, read ack in cycle 4.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and address-slice constants for the
// Wishbone-to-asynchronous-SRAM controller.
package sram_ctrl_pkg;

  // READ_3 is only reached when the extra-wait build option is enabled.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    READ_2  = 3'd2,
    READ_3  = 3'd3,
    WRITE   = 3'd4,
    WRITE_2 = 3'd5,
    WRITE_3 = 3'd6,
    DONE    = 3'd7
  } sram_state_t;

  // Byte address bits that select one 32-bit SRAM word.
  localparam int SRAM_WORD_LSB = 2;
  localparam int SRAM_WORD_MSB = 21;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: single-word Wishbone classic responder driving one
// asynchronous 1M x 32 SRAM bank. Every output is registered; the shared data
// bus is released except while a write cycle is in flight.
// Build option: define SRAM_CTRL_EXTRA_WAIT_EN to add one read wait state
// (READ_3) and stretch the write-enable pulse to two cycles.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                    clk_50M,
  input  logic                    reset_btn,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  inout  wire  [DATA_WIDTH-1:0]   sram_data,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int BE_W = DATA_WIDTH / 8;

  // The state in which read data is captured from the SRAM bus.
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
  localparam sram_state_t READ_LAST = READ_3;
`else
  localparam sram_state_t READ_LAST = READ_2;
`endif

  sram_state_t             state_reg, state_next;
  logic                    aborted_reg, aborted_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [BE_W-1:0]         be_lat_reg, be_lat_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                    ack_reg, ack_next;
  logic                    ce_n_reg, ce_n_next;
  logic                    oe_n_reg, oe_n_next;
  logic                    we_n_reg, we_n_next;
  logic [BE_W-1:0]         be_n_reg, be_n_next;
  logic                    drive_reg, drive_next;
  logic                    accept;
  logic                    active_next;
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
  logic                    wait_reg, wait_next;
`endif

  // Only the word-select bits of the byte address reach the SRAM.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:SRAM_WORD_LSB+ADDR_WIDTH],
                             wb_adr_i[SRAM_WORD_LSB-1:0]};

  // Next-state, request latching and abort tracking.
  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    addr_next    = addr_reg;
    be_lat_next  = be_lat_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
    wait_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          accept     = 1'b1;
          state_next = wb_we_i ? WRITE : READ;
        end
      end
      READ:    state_next = READ_2;
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
      READ_2:  state_next = READ_3;
      READ_3:  state_next = DONE;
`else
      READ_2:  state_next = DONE;
`endif
      WRITE:   state_next = WRITE_2;
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
      WRITE_2: begin
        // First WRITE_2 cycle arms the wait flag; the second one moves on.
        if (!wait_reg) wait_next  = 1'b1;
        else           state_next = WRITE_3;
      end
`else
      WRITE_2: state_next = WRITE_3;
`endif
      WRITE_3: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      addr_next   = wb_adr_i[SRAM_WORD_LSB +: ADDR_WIDTH];
      be_lat_next = ~wb_sel_i;
      wdata_next  = wb_dat_i;
    end

    if (state_reg == READ_LAST) rdata_next = sram_data;

    // Once the master drops cyc the SRAM cycle still runs to completion,
    // but the acknowledge is suppressed.
    if (accept)                                aborted_next = 1'b0;
    else if (state_reg != IDLE && !wb_cyc_i)   aborted_next = 1'b1;
    else                                       aborted_next = aborted_reg;
  end

  // Registered SRAM strobes and ack, derived from the state being entered.
  always_comb begin
    active_next = (state_next != IDLE) && (state_next != DONE);
    ce_n_next   = !active_next;
    oe_n_next   = !((state_next == READ) || (state_next == READ_2) ||
                    (state_next == READ_3));
    we_n_next   = (state_next != WRITE_2);
    drive_next  = (state_next == WRITE) || (state_next == WRITE_2) ||
                  (state_next == WRITE_3);
    be_n_next   = active_next ? be_lat_next : {BE_W{1'b1}};
    ack_next    = (state_next == DONE) && !aborted_next;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state_reg   <= IDLE;
      aborted_reg <= 1'b0;
      addr_reg    <= '0;
      be_lat_reg  <= {BE_W{1'b1}};
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      ack_reg     <= 1'b0;
      ce_n_reg    <= 1'b1;
      oe_n_reg    <= 1'b1;
      we_n_reg    <= 1'b1;
      be_n_reg    <= {BE_W{1'b1}};
      drive_reg   <= 1'b0;
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
      wait_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      aborted_reg <= aborted_next;
      addr_reg    <= addr_next;
      be_lat_reg  <= be_lat_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      ack_reg     <= ack_next;
      ce_n_reg    <= ce_n_next;
      oe_n_reg    <= oe_n_next;
      we_n_reg    <= we_n_next;
      be_n_reg    <= be_n_next;
      drive_reg   <= drive_next;
`ifdef SRAM_CTRL_EXTRA_WAIT_EN
      wait_reg    <= wait_next;
`endif
    end
  end

  assign sram_data = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
  assign sram_addr = addr_reg;
  assign sram_ce_n = ce_n_reg;
  assign sram_oe_n = oe_n_reg;
  assign sram_we_n = we_n_reg;
  assign sram_be_n = be_n_reg;
  assign wb_ack_o  = ack_reg;
  assign wb_dat_o  = rdata_reg;

endmodule
